// File: rtl/flash_pkg.sv
// Shared constants, state encoding and sizing helper for the SPI flash reader.
package flash_pkg;

  localparam logic [7:0]  FLASH_CMD_READ = 8'h03;
  localparam int unsigned CMD_BITS       = 32;
  localparam int unsigned WORD_BITS      = 16;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    CMDADDR,
    DATA,
    OUT,
    END
  } state_e;

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: SCK half-period divider, MOSI shift-out on falling
// edges, MISO shift-in on rising edges. Holds its phase while run is low.
module spi_bit_engine
  import flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CMD_BITS-1:0]  load_data,
  input  logic                 run,
  input  logic                 miso,
  output logic                 sck,
  output logic                 mosi,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 low_end
);

  localparam int unsigned          DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sck_q, sck_d;
  logic [CMD_BITS-1:0]  tx_q, tx_d;
  logic [WORD_BITS-1:0] rx_q, rx_d;
  logic                 half_end;

  assign half_end = (div_q == DIV_LAST);
  // Final cycle of a low half: the next running edge raises SCK.
  assign low_end  = half_end && !sck_q;

  // Divider, SCK toggle and the two shift registers.
  always_comb begin
    div_d = div_q;
    sck_d = sck_q;
    tx_d  = tx_q;
    rx_d  = rx_q;
    if (load) begin
      div_d = '0;
      sck_d = 1'b0;
      tx_d  = load_data;
    end else if (run) begin
      if (half_end) begin
        div_d = '0;
        sck_d = !sck_q;
        if (sck_q) begin
          tx_d = {tx_q[CMD_BITS-2:0], 1'b0};
        end else begin
          rx_d = {rx_q[WORD_BITS-2:0], miso};
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      sck_q <= 1'b0;
      tx_q  <= '0;
      rx_q  <= '0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
      tx_q  <= tx_d;
      rx_q  <= rx_d;
    end
  end

  assign sck     = sck_q;
  assign mosi    = tx_q[CMD_BITS-1];
  assign rx_data = rx_q;

endmodule

// File: rtl/flash_reader.sv
// SPI flash read initiator: issues READ + 24-bit address, then streams
// big-endian 16-bit words over a valid/ready interface.
module flash_reader
  import flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned CS_IDLE = 2
) (
  input  logic             clk_vga,
  input  logic             rst_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic [15:0]      word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             done,
  output logic             flash_ss,
  output logic             flash_sck,
  output logic             flash_mosi,
  input  logic             flash_miso
);

  localparam int unsigned      IDLE_W        = cnt_width(CS_IDLE);
  localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(CS_IDLE - 1);
  localparam logic [4:0]        LAST_CMD_BIT  = 5'(CMD_BITS - 1);
  localparam logic [4:0]        LAST_DATA_BIT = 5'(WORD_BITS - 1);

  state_e                 state_q, state_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [WORD_BITS-1:0]   word_q, word_d;
  logic                   done_q, done_d;
  logic                   ss_q, ss_d;
  logic                   eng_load, eng_run, low_end;
  logic [WORD_BITS-1:0]   rx_data;

  spi_bit_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk       (clk_vga),
    .rst_n     (rst_n),
    .load      (eng_load),
    .load_data ({FLASH_CMD_READ, addr}),
    .run       (eng_run),
    .miso      (flash_miso),
    .sck       (flash_sck),
    .mosi      (flash_mosi),
    .rx_data   (rx_data),
    .low_end   (low_end)
  );

  // Next-state, counters and engine control.
  // SEL is treated as a leading low half so its end raises SCK for bit 0.
  // The engine is halted on the last data low half, leaving its divider at
  // the end of a low half; the OUT handshake then raises SCK immediately.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rem_d     = rem_q;
    idle_d    = idle_q;
    word_d    = word_q;
    done_d    = 1'b0;
    eng_load  = 1'b0;
    eng_run   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d   = SEL;
            rem_d     = len;
            bit_cnt_d = '0;
            eng_load  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEL: begin
        eng_run = 1'b1;
        if (low_end) begin
          state_d   = CMDADDR;
          bit_cnt_d = '0;
        end
      end
      CMDADDR: begin
        eng_run = 1'b1;
        if (low_end) begin
          if (bit_cnt_q == LAST_CMD_BIT) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (low_end && (bit_cnt_q == LAST_DATA_BIT)) begin
          state_d = OUT;
          word_d  = rx_data;
        end else begin
          eng_run = 1'b1;
          if (low_end) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      OUT: begin
        if (word_ready) begin
          if (rem_q != '0) begin
            rem_d = rem_q - LEN_W'(1);
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = END;
            idle_d  = '0;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
            eng_run   = 1'b1;
          end
        end
      end
      END: begin
        if (idle_q == IDLE_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ss_d = !(state_d inside {SEL, CMDADDR, DATA, OUT});
  end

  // Controller state register.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rem_q     <= '0;
      idle_q    <= '0;
      word_q    <= '0;
      done_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rem_q     <= rem_d;
      idle_q    <= idle_d;
      word_q    <= word_d;
      done_q    <= done_d;
      ss_q      <= ss_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign word_valid = (state_q == OUT);
  assign word       = word_q;
  assign done       = done_q;
  assign flash_ss   = ss_q;

endmodule

// File: tb/tb_flash_reader.sv
// Self-checking bench: two readers (CLK_DIV 1 and 3), each with a behavioural
// SPI flash serving a shared 256-byte image (address wraps modulo 256).
module tb_flash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       start;
  logic [23:0]      addr;
  logic [15:0]      len;
  logic             ready;
  logic [1:0]       busy, valid, done, ss, sck, mosi;
  logic [1:0][15:0] word;
  logic [1:0][31:0] cmd_cap;
  logic [7:0]       image [256];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    int unsigned rises;
    int unsigned idx;
    logic [31:0] cmd_l;
    logic [7:0]  bi;
    logic        miso_l;

    initial begin
      rises  = 0;
      idx    = 0;
      cmd_l  = '0;
      bi     = '0;
      miso_l = 1'b0;
    end

    // Flash: first 32 rises capture command+address, then bytes go out MSB
    // first, each bit presented after a falling SCK edge.
    always @(posedge sck[g] or negedge sck[g] or posedge ss[g]) begin
      if (ss[g]) begin
        rises  = 0;
        miso_l = 1'b0;
      end else if (sck[g]) begin
        if (rises < 32) cmd_l = {cmd_l[30:0], mosi[g]};
        rises++;
      end else if (rises >= 32) begin
        idx    = rises - 32;
        bi     = cmd_l[7:0] + 8'(idx / 8);
        miso_l = image[bi][7 - (idx % 8)];
      end
    end

    assign cmd_cap[g] = cmd_l;

    flash_reader #(
      .CLK_DIV (g == 0 ? 1 : 3),
      .LEN_W   (16),
      .CS_IDLE (2)
    ) u_dut (
      .clk_vga    (clk),
      .rst_n      (rst_n),
      .start      (start[g]),
      .addr       (addr),
      .len        (len),
      .busy       (busy[g]),
      .word       (word[g]),
      .word_valid (valid[g]),
      .word_ready (ready),
      .done       (done[g]),
      .flash_ss   (ss[g]),
      .flash_sck  (sck[g]),
      .flash_mosi (mosi[g]),
      .flash_miso (miso_l)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input int s, input string tag);
    check({tag, "_busy"},  32'(busy[s]),  32'd0);
    check({tag, "_word"},  32'(word[s]),  32'd0);
    check({tag, "_valid"}, 32'(valid[s]), 32'd0);
    check({tag, "_done"},  32'(done[s]),  32'd0);
    check({tag, "_ss"},    32'(ss[s]),    32'd1);
    check({tag, "_sck"},   32'(sck[s]),   32'd0);
    check({tag, "_mosi"},  32'(mosi[s]),  32'd0);
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 hold ready low on word
  // index stall_w for stall_len valid cycles.
  task automatic do_txn(input int s, input logic [23:0] a, input logic [15:0] n,
                        input int rmode, input int stall_w, input int stall_len,
                        input int exp_first, input bit poke);
    logic [15:0] exp_q [$];
    logic [15:0] held;
    logic [15:0] e;
    logic        r;
    bit          was_wait;
    int          cyc, acc, stall_cnt, first;
    for (int k = 0; k < int'(n); k++)
      exp_q.push_back({image[8'(a[7:0] + 8'(2 * k))], image[8'(a[7:0] + 8'(2 * k + 1))]});
    held = '0; was_wait = 0; acc = 0; stall_cnt = 0; first = 0;
    addr = a; len = n; start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    cyc = 1;
    check("busy_after_start", 32'(busy[s]), 32'd1);
    check("ss_low_cycle1", 32'(ss[s]), 32'd0);
    while (1) begin
      if (cyc > 20000) begin
        check("timeout_done", 32'(done[s]), 32'd1);
        break;
      end
      if (ss[s]) check("sck_idle", 32'(sck[s]), 32'd0);
      if (was_wait) begin
        check("hold_word",  32'(word[s]),  32'(held));
        check("hold_valid", 32'(valid[s]), 32'd1);
        check("stall_sck",  32'(sck[s]),   32'd0);
        check("stall_ss",   32'(ss[s]),    32'd0);
      end
      if (valid[s] && first == 0) first = cyc;
      if (done[s]) break;
      if (poke && cyc == 40) begin
        addr = ~a & 24'hFFFFFE;
        start[s] = 1'b1;
      end else begin
        start[s] = 1'b0;
      end
      case (rmode)
        1:       r = ($urandom_range(0, 3) != 0);
        2: begin
          r = 1'b1;
          if (valid[s] && acc == stall_w && stall_cnt < stall_len) begin
            r = 1'b0;
            stall_cnt++;
          end
        end
        default: r = 1'b1;
      endcase
      ready = r;
      was_wait = valid[s] && !r;
      held = word[s];
      if (valid[s] && r) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(word[s]), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("word", 32'(word[s]), 32'(e));
        end
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start[s] = 1'b0;
    check("word_count", 32'(acc), 32'(n));
    check("busy_at_done", 32'(busy[s]), 32'd0);
    check("cmd_addr", cmd_cap[s], {8'h03, a});
    if (exp_first != 0) check("first_valid_cycle", 32'(first), 32'(exp_first));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("done_single", 32'(done[s]), 32'd0);
      check("ss_high_after", 32'(ss[s]), 32'd1);
    end
  endtask

  task automatic zero_len(input int s);
    addr = 24'($urandom()) & 24'hFFFFFE;
    len = '0;
    start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    check("len0_done", 32'(done[s]), 32'd1);
    check("len0_ss", 32'(ss[s]), 32'd1);
    check("len0_busy", 32'(busy[s]), 32'd0);
    @(posedge clk); #1;
    check("len0_done_once", 32'(done[s]), 32'd0);
    check("len0_ss_after", 32'(ss[s]), 32'd1);
  endtask

  task automatic abort_test();
    addr = 24'($urandom()) & 24'hFFFFFE;
    len = 16'd2;
    ready = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (69) @(posedge clk);
    #3;
    check("pre_abort_ss", 32'(ss[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset(0, "abort");
    @(posedge clk); #1;
    check_reset(0, "abort_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [23:0] ra;
    rst_n = 1'b0;
    start = '0;
    addr  = '0;
    len   = '0;
    ready = 1'b0;
    for (int i = 0; i < 256; i++) image[i] = 8'($urandom());
    image[0] = 8'hDE;
    image[1] = 8'hAD;
    image[2] = 8'hBE;
    image[3] = 8'hEF;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) check_reset(s, "reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn(0, 24'h000000, 16'd2, 0, 0, 0, 98, 0);
    do_txn(0, 24'h012346, 16'd1, 0, 0, 0, 98, 0);
    ra = 24'($urandom()) & 24'hFFFFFE;
    do_txn(0, ra, 16'd3, 2, 1, 20, 98, 0);
    zero_len(0);
    ra = 24'($urandom()) & 24'hFFFFFE;
    do_txn(0, ra, 16'd2, 0, 0, 0, 98, 1);
    abort_test();
    ra = 24'($urandom()) & 24'hFFFFFE;
    do_txn(0, ra, 16'd2, 1, 0, 0, 98, 0);
    ra = 24'($urandom()) & 24'hFFFFFE;
    do_txn(1, ra, 16'd1, 0, 0, 0, 292, 0);
    for (int t = 0; t < 6; t++) begin
      ra = 24'($urandom()) & 24'hFFFFFE;
      do_txn(0, ra, 16'($urandom_range(1, 5)), 1, 0, 0, 98, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
